// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SEQ  = 4'd6;
    localparam logic [3:0] OP_ABS  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative shift / shift-add multiply datapath with down-counter; done_o marks the final step.
// The multiply path exists only when ALU_SEQ_MUL_EN is defined.
module alu_seq_shifter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [3:0]         op_i,
    input  logic [SHAMT_W-1:0] cnt_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o,
    output logic               hi_nz_o
);

    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   data_q;
    logic               left_q;
    logic [WIDTH-1:0]   data_step;

    assign data_step = left_q ? (data_q << 1) : (data_q >> 1);
    // done is asserted on the last step so the top registers the stepped value directly
    assign done_o    = (cnt_q == SHAMT_W'(1));

`ifdef ALU_SEQ_MUL_EN
    logic                 mul_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_step;

    assign acc_step = acc_q + (data_q[0] ? mcand_q : '0);
    assign result_o = mul_q ? acc_step[WIDTH-1:0] : data_step;
    assign hi_nz_o  = mul_q & (|acc_step[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mul_q   <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else if (start_i) begin
            mul_q   <= (op_i == OP_MUL);
            mcand_q <= {{WIDTH{1'b0}}, a_i};
            acc_q   <= '0;
        end else if (cnt_q != '0) begin
            mcand_q <= mcand_q << 1;
            acc_q   <= acc_step;
        end
    end
`else
    assign result_o = data_step;
    assign hi_nz_o  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            data_q <= '0;
            left_q <= 1'b0;
        end else if (start_i) begin
            cnt_q  <= cnt_i;
            left_q <= (op_i == OP_SLL);
`ifdef ALU_SEQ_MUL_EN
            // multiplier walks right through data_q, one partial product per cycle
            data_q <= (op_i == OP_MUL) ? b_i : a_i;
`else
            data_q <= a_i;
`endif
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - SHAMT_W'(1);
            data_q <= data_step;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: one op in flight, result held until accepted.
// Optional iterative multiply enabled by defining ALU_SEQ_MUL_EN.
//
//   state  | meaning
//   S_IDLE | ready for a request
//   S_CALC | iterating a shift or multiply
//   S_HOLD | result valid, waiting for ready_i
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             set_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             busy_o
);

    state_t             state;
    logic               calc_mul_q;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   abs_v;
    logic [WIDTH-1:0]   min_neg;
    logic [SHAMT_W-1:0] amt;
    logic               is_shift;
    logic               is_mul;
    logic               is_iter;
    logic               start;
    logic [WIDTH-1:0]   res_n;
    logic               set_n;
    logic               carry_n;
    logic               ovf_n;
    logic               sh_done;
    logic [WIDTH-1:0]   sh_result;
    logic               sh_hi_nz;

    assign add_w    = {1'b0, rs_i} + {1'b0, rt_i};
    assign sub_w    = {1'b0, rs_i} - {1'b0, rt_i};
    assign min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
    assign abs_v    = rs_i[WIDTH-1] ? (~rs_i + WIDTH'(1)) : rs_i;
    assign amt      = (rt_i >= WIDTH'(WIDTH)) ? SHAMT_W'(WIDTH) : rt_i[SHAMT_W-1:0];
    assign is_shift = (opcode_i == OP_SLL) || (opcode_i == OP_SRL);
`ifdef ALU_SEQ_MUL_EN
    assign is_mul   = (opcode_i == OP_MUL);
`else
    assign is_mul   = 1'b0;
`endif
    assign is_iter  = (is_shift && (amt != '0)) || is_mul;
    assign start    = (state == S_IDLE) && valid_i && is_iter;

    always_comb begin
        res_n   = '0;
        set_n   = set_o;
        carry_n = carry_o;
        ovf_n   = ovf_o;
        case (opcode_i)
            OP_AND:  res_n = rs_i & rt_i;
            OP_ADD: begin
                res_n   = add_w[WIDTH-1:0];
                carry_n = add_w[WIDTH];
                ovf_n   = (rs_i[WIDTH-1] == rt_i[WIDTH-1]) && (add_w[WIDTH-1] != rs_i[WIDTH-1]);
            end
            OP_SUB: begin
                res_n   = sub_w[WIDTH-1:0];
                carry_n = sub_w[WIDTH];
                ovf_n   = (rs_i[WIDTH-1] != rt_i[WIDTH-1]) && (sub_w[WIDTH-1] != rs_i[WIDTH-1]);
            end
            OP_SLL, OP_SRL: res_n = rs_i;
            OP_SLT: begin
                set_n = ($signed(rs_i) < $signed(rt_i));
                res_n = WIDTH'(set_n);
            end
            OP_SEQ: begin
                set_n = (rs_i == rt_i);
                res_n = WIDTH'(set_n);
            end
            OP_ABS: begin
                res_n = abs_v;
                ovf_n = (rs_i == min_neg);
            end
            OP_PASS: res_n = rt_i;
            default: res_n = '0;
        endcase
    end

    alu_seq_shifter #(
        .WIDTH  (WIDTH),
        .SHAMT_W(SHAMT_W)
    ) u_shifter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start),
        .op_i    (opcode_i),
        .cnt_i   (is_mul ? SHAMT_W'(WIDTH) : amt),
        .a_i     (rs_i),
        .b_i     (rt_i),
        .done_o  (sh_done),
        .result_o(sh_result),
        .hi_nz_o (sh_hi_nz)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            calc_mul_q <= 1'b0;
            result_o   <= '0;
            set_o      <= 1'b0;
            carry_o    <= 1'b0;
            ovf_o      <= 1'b0;
            valid_o    <= 1'b0;
            ready_o    <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                        if (is_iter) begin
                            state      <= S_CALC;
                            calc_mul_q <= is_mul;
                        end else begin
                            state    <= S_HOLD;
                            valid_o  <= 1'b1;
                            result_o <= res_n;
                            set_o    <= set_n;
                            carry_o  <= carry_n;
                            ovf_o    <= ovf_n;
                        end
                    end
                end
                S_CALC: begin
                    if (sh_done) begin
                        state    <= S_HOLD;
                        valid_o  <= 1'b1;
                        result_o <= sh_result;
                        if (calc_mul_q) ovf_o <= sh_hi_nz;
                    end
                end
                S_HOLD: begin
                    if (ready_i) begin
                        state   <= S_IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
